fb_write_scheduler: RTL and testbench

Owns the single SDPB frame-buffer write port and shares it between two requesters: the pixel stream from memory_controller (valid/ready) and an internal clear/fill engine. The fill engine sweeps every frame-buffer address with one colour at one pixel per clock. The block also counts accepted stream pixels and flags a complete frame. It sits between memory_controller's mem_* outputs and the SDPB write port.

---
 rtl/fb_wr_if.sv | 12 +
 rtl/fb_write_scheduler.sv | 88 ++++++++
 tb/tb_fb_write_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fb_wr_if.sv
// fb_wr_if: stream pixel write handshake into the frame-buffer write scheduler
interface fb_wr_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
);
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_valid;
  logic              wr_ready;
  modport master (output wr_data, wr_addr, wr_valid, input wr_ready);
  modport slave  (input wr_data, wr_addr, wr_valid, output wr_ready);
endinterface

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: shares the SDPB write port between the pixel stream and a clear/fill engine.
// Define FB_WR_BOUNDS_CHECK_EN to drop (and flag on wr_oob) stream writes at addresses >= FB_DEPTH.
module fb_write_scheduler #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 3,
  parameter int FB_DEPTH = 19200
) (
  input  logic              clk,
  input  logic              rst,
  fb_wr_if.slave            wr,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              frame_done,
  output logic              wr_oob,
  output logic [DATA_W-1:0] sdpb_wdata,
  output logic [ADDR_W-1:0] sdpb_waddr,
  output logic              sdpb_wen
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W:0] LAST  = DEPTH - 1'b1;
  logic [0:0]        state;
  logic [ADDR_W:0]   fill_cnt;
  logic [ADDR_W:0]   pix_cnt;
  logic [DATA_W-1:0] color;
  logic              accept;
  logic              oob;
  assign wr.wr_ready = (state == IDLE) && !clr_start;
  assign accept      = wr.wr_valid && wr.wr_ready;
`ifdef FB_WR_BOUNDS_CHECK_EN
  assign oob = accept && ({1'b0, wr.wr_addr} >= DEPTH);
`else
  assign oob = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      pix_cnt    <= '0;
      color      <= '0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      frame_done <= 1'b0;
      wr_oob     <= 1'b0;
      sdpb_wdata <= '0;
      sdpb_waddr <= '0;
      sdpb_wen   <= 1'b0;
    end else begin
      clr_done   <= 1'b0;
      frame_done <= 1'b0;
      wr_oob     <= 1'b0;
      sdpb_wen   <= 1'b0;
      if (state == IDLE) begin
        if (clr_start) begin
          state      <= CLEAR;
          color      <= clr_color;
          clr_busy   <= 1'b1;
          sdpb_wen   <= 1'b1;
          sdpb_waddr <= '0;
          sdpb_wdata <= clr_color;
          fill_cnt   <= {{ADDR_W{1'b0}}, 1'b1};
        end else if (oob) begin
          wr_oob <= 1'b1;
        end else if (accept) begin
          sdpb_wen   <= 1'b1;
          sdpb_waddr <= wr.wr_addr;
          sdpb_wdata <= wr.wr_data;
          frame_done <= (pix_cnt == LAST);
          pix_cnt    <= (pix_cnt == LAST) ? '0 : pix_cnt + 1'b1;
        end
      end else if (fill_cnt == DEPTH) begin
        // last address went out on the previous edge; stream resumes next cycle
        state    <= IDLE;
        clr_busy <= 1'b0;
        clr_done <= 1'b1;
        pix_cnt  <= '0;
      end else begin
        sdpb_wen   <= 1'b1;
        sdpb_waddr <= fill_cnt[ADDR_W-1:0];
        sdpb_wdata <= color;
        fill_cnt   <= fill_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed table plus hand sequences for fill, reset abort and frame counting
module tb_fb_write_scheduler;
  localparam int AW = 5;
  localparam int DW = 3;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic clr_busy, clr_done, frame_done, wr_oob, sdpb_wen;
  logic [DW-1:0] sdpb_wdata;
  logic [AW-1:0] sdpb_waddr;
  int n_chk = 0;
  int n_err = 0;
  fb_wr_if #(.ADDR_W(AW), .DATA_W(DW)) s ();
  fb_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(s), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done), .frame_done(frame_done), .wr_oob(wr_oob),
    .sdpb_wdata(sdpb_wdata), .sdpb_waddr(sdpb_waddr), .sdpb_wen(sdpb_wen)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rdy;
    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_wen"}, sdpb_wen, 0);
    chk({nm, "_waddr"}, sdpb_waddr, 0);
    chk({nm, "_wdata"}, sdpb_wdata, 0);
    chk({nm, "_busy"}, clr_busy, 0);
    chk({nm, "_done"}, clr_done, 0);
    chk({nm, "_frame"}, frame_done, 0);
    chk({nm, "_oob"}, wr_oob, 0);
  endtask
  initial begin
    int acc, cyc, last;
    logic hit, seen;
    tbl[0] = '{1'b1, 5'd5,  3'd5, 1'b1, 1'b1, 5'd5,  3'd5};
    tbl[1] = '{1'b0, 5'd17, 3'd1, 1'b1, 1'b0, 5'd5,  3'd5};
    tbl[2] = '{1'b1, 5'd3,  3'd2, 1'b1, 1'b1, 5'd3,  3'd2};
    tbl[3] = '{1'b1, 5'd9,  3'd6, 1'b1, 1'b1, 5'd9,  3'd6};
    tbl[4] = '{1'b0, 5'd0,  3'd0, 1'b1, 1'b0, 5'd9,  3'd6};
    s.wr_valid = 1'b0; s.wr_addr = '0; s.wr_data = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s.wr_valid = tbl[i].v; s.wr_addr = tbl[i].a; s.wr_data = tbl[i].d;
      #1 chk($sformatf("tbl%0d_ready", i), s.wr_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_wen", i), sdpb_wen, tbl[i].wen);
      chk($sformatf("tbl%0d_waddr", i), sdpb_waddr, tbl[i].wa);
      chk($sformatf("tbl%0d_wdata", i), sdpb_wdata, tbl[i].wd);
    end
    // asynchronous reset while a stream write is being presented
    @(negedge clk);
    s.wr_valid = 1'b1; s.wr_addr = 5'd12; s.wr_data = 3'd3;
    @(posedge clk);
    #1 chk("pre_rst_wen", sdpb_wen, 1);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0; s.wr_valid = 1'b0;
    // fill requested alongside a stream pixel; pixel must wait for the fill
    @(negedge clk);
    s.wr_valid = 1'b1; s.wr_addr = 5'd7; s.wr_data = 3'd1;
    clr_start = 1'b1; clr_color = 3'b010;
    #1 chk("clr_ready0", s.wr_ready, 0);
    @(posedge clk);
    #1;
    chk("fill0_wen", sdpb_wen, 1);
    chk("fill0_waddr", sdpb_waddr, 0);
    chk("fill0_wdata", sdpb_wdata, 2);
    chk("fill0_busy", clr_busy, 1);
    @(negedge clk);
    clr_start = 1'b0; clr_color = 3'd5;
    for (int i = 1; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("fill%0d_wen", i), sdpb_wen, 1);
      chk($sformatf("fill%0d_waddr", i), sdpb_waddr, i);
      chk($sformatf("fill%0d_wdata", i), sdpb_wdata, 2);
      chk($sformatf("fill%0d_busy", i), clr_busy, 1);
      chk($sformatf("fill%0d_done", i), clr_done, 0);
      chk($sformatf("fill%0d_ready", i), s.wr_ready, 0);
    end
    @(posedge clk);
    #1;
    chk("fill_end_wen", sdpb_wen, 0);
    chk("fill_end_busy", clr_busy, 0);
    chk("fill_end_done", clr_done, 1);
    chk("fill_end_ready", s.wr_ready, 1);
    @(posedge clk);
    #1;
    chk("held_wen", sdpb_wen, 1);
    chk("held_waddr", sdpb_waddr, 7);
    chk("held_wdata", sdpb_wdata, 1);
    chk("held_done", clr_done, 0);
    @(negedge clk) s.wr_valid = 1'b0;
    // abort a fill with reset once address 7 is on the port
    @(negedge clk);
    clr_start = 1'b1; clr_color = 3'd3;
    @(negedge clk) clr_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(posedge clk);
      #1 hit = sdpb_wen && sdpb_waddr == 5'd7;
    end
    chk("abort_reach7", hit, 1);
    #2 rst = 1'b1;
    #1 chk_zero("abort_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("abort_ready", s.wr_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 seen = seen | clr_done | clr_busy;
    end
    chk("abort_no_done", seen, 0);
    // frame counting with random stalls
    acc = 0; cyc = 0;
    while (acc < 17 && cyc < 300) begin
      @(negedge clk);
      s.wr_valid = ($urandom_range(0, 2) != 0);
      s.wr_addr = AW'(acc); s.wr_data = DW'(acc);
      @(posedge clk);
      #1;
      if (s.wr_valid) acc++;
      chk($sformatf("frame_wen_c%0d", cyc), sdpb_wen, s.wr_valid);
      chk($sformatf("frame_done_c%0d_a%0d", cyc, acc), frame_done, s.wr_valid && acc == 16);
      cyc++;
    end
    chk("frame_accepts", acc, 17);
    @(negedge clk) s.wr_valid = 1'b0;
    // out-of-range stream write, followed by a full frame to expose the pixel count
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    s.wr_valid = 1'b1; s.wr_addr = 5'd20; s.wr_data = 3'd4;
    #1 chk("oob_ready", s.wr_ready, 1);
    @(posedge clk);
    #1;
`ifdef FB_WR_BOUNDS_CHECK_EN
    chk("oob_wen", sdpb_wen, 0);
    chk("oob_flag", wr_oob, 1);
    last = DEPTH - 1;
`else
    chk("oob_wen", sdpb_wen, 1);
    chk("oob_waddr", sdpb_waddr, 20);
    chk("oob_flag", wr_oob, 0);
    last = DEPTH - 2;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      s.wr_addr = AW'(i); s.wr_data = DW'(i);
      @(posedge clk);
      #1;
      chk($sformatf("oobf%0d_frame", i), frame_done, i == last);
      chk($sformatf("oobf%0d_oob", i), wr_oob, 0);
    end
    @(negedge clk) s.wr_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
